// File: rtl/quad_logger_pkg.sv
// rtl/quad_logger_pkg.sv - entry layout and sizing helpers shared by the position logger
// QPL_TIMESTAMP_EN adds the timestamp field to qpl_entry_t and to the entry width.
package quad_logger_pkg;

   localparam int QPL_DEF_POSITION_SIZE = 6;
   localparam int QPL_DEF_TS_SIZE       = 32;

`ifdef QPL_TIMESTAMP_EN
   localparam bit QPL_TS_EN = 1'b1;
`else
   localparam bit QPL_TS_EN = 1'b0;
`endif

   typedef struct packed {
`ifdef QPL_TIMESTAMP_EN
      logic [QPL_DEF_TS_SIZE-1:0]       ts;
`endif
      logic                             dir;
      logic [QPL_DEF_POSITION_SIZE-1:0] pos;
   } qpl_entry_t;

   function automatic int qpl_entry_width(input int position_size, input int ts_size);
      return (QPL_TS_EN ? ts_size : 0) + 1 + position_size;
   endfunction

   function automatic bit qpl_depth_ok(input int depth);
      return (depth >= 4) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO with a registered output stage
// count covers the memory plus the output register; full/empty derive from count only.
module sync_fifo_fwft #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             tready,
   output logic [WIDTH-1:0] tdata,
   output logic             tvalid,
   output logic [CW-1:0]    count,
   output logic             full
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop;
   logic             mem_has_data;
   logic             load;

   assign pop          = tvalid & tready;
   assign mem_has_data = (count != CW'(tvalid));
   assign load         = mem_has_data & (~tvalid | pop);
   assign full         = (count == CW'(DEPTH));

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // A freshly pushed word reaches the output register one cycle later; there is no bypass.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         tvalid <= 1'b0;
         tdata  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         tvalid <= 1'b0;
         tdata  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (load) begin
            tdata  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + AW'(1);
            tvalid <= 1'b1;
         end else if (pop) begin
            tvalid <= 1'b0;
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: rtl/quad_position_logger.sv
// rtl/quad_position_logger.sv - logs decoder position on trigger rising edges into a stream FIFO
// Define QPL_TIMESTAMP_EN to prepend a free-running timestamp to every logged entry.
module quad_position_logger
   import quad_logger_pkg::*;
#(
   parameter int POSITION_SIZE = QPL_DEF_POSITION_SIZE,
   parameter int DEPTH         = 16,
   parameter int TS_SIZE       = QPL_DEF_TS_SIZE,
   parameter int DROP_CNT_SIZE = 8,
   localparam int W  = qpl_entry_width(POSITION_SIZE, TS_SIZE),
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic                     i_clk,
   input  logic                     i_aresetn,
   input  logic                     i_clear,
   input  logic                     i_trigger,
   input  logic [POSITION_SIZE-1:0] i_position,
   input  logic                     i_direction,
   output logic [W-1:0]             o_tdata,
   output logic                     o_tvalid,
   input  logic                     i_tready,
   output logic [CW-1:0]            o_count,
   output logic                     o_overflow,
   output logic [DROP_CNT_SIZE-1:0] o_drop_cnt
);

   if (!qpl_depth_ok(DEPTH)) begin : g_depth_chk
      $error("quad_position_logger: DEPTH must be a power of two >= 4");
   end
   if (qpl_entry_width(QPL_DEF_POSITION_SIZE, QPL_DEF_TS_SIZE) != $bits(qpl_entry_t)) begin : g_entry_chk
      $error("quad_position_logger: qpl_entry_t and entry width disagree");
   end

   logic         trig_q;
   logic         trig_event;
   logic         pop;
   logic         full;
   logic         push;
   logic         drop;
   logic [W-1:0] entry;

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         trig_q <= 1'b0;
      end else begin
         trig_q <= i_trigger;
      end
   end

   assign trig_event = i_trigger & ~trig_q;
   assign pop        = o_tvalid & i_tready;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the event.
   assign push       = trig_event & ~i_clear & (~full | pop);
   assign drop       = trig_event & ~i_clear & full & ~pop;

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         o_overflow <= 1'b0;
         o_drop_cnt <= '0;
      end else if (i_clear) begin
         o_overflow <= 1'b0;
         o_drop_cnt <= '0;
      end else if (drop) begin
         o_overflow <= 1'b1;
         if (o_drop_cnt != '1) begin
            o_drop_cnt <= o_drop_cnt + DROP_CNT_SIZE'(1);
         end
      end
   end

`ifdef QPL_TIMESTAMP_EN
   logic [TS_SIZE-1:0] ts_q;

   always_ff @(posedge i_clk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         ts_q <= '0;
      end else if (i_clear) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + TS_SIZE'(1);
      end
   end

   assign entry = {ts_q, i_direction, i_position};
`else
   assign entry = {i_direction, i_position};
`endif

   sync_fifo_fwft #(
      .DEPTH (DEPTH),
      .WIDTH (W)
   ) u_fifo (
      .clk       (i_clk),
      .aresetn   (i_aresetn),
      .clear     (i_clear),
      .push      (push),
      .push_data (entry),
      .tready    (i_tready),
      .tdata     (o_tdata),
      .tvalid    (o_tvalid),
      .count     (o_count),
      .full      (full)
   );

endmodule

// File: tb/tb_quad_position_logger.sv
// tb/tb_quad_position_logger.sv - randomized bench with a queue model of the position logger
module tb_quad_position_logger;

   localparam int DEPTH = 16;
`ifdef QPL_TIMESTAMP_EN
   localparam int W = 39;
`else
   localparam int W = 7;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clr;
   logic         trig;
   logic [5:0]   pos;
   logic         dir;
   logic         rdy;
   logic [W-1:0] tdata;
   logic         tvalid;
   logic [4:0]   count;
   logic         ovf;
   logic [7:0]   drop_cnt;

   always #5 clk = ~clk;

   quad_position_logger dut (
      .i_clk       (clk),
      .i_aresetn   (rst_n),
      .i_clear     (clr),
      .i_trigger   (trig),
      .i_position  (pos),
      .i_direction (dir),
      .o_tdata     (tdata),
      .o_tvalid    (tvalid),
      .i_tready    (rdy),
      .o_count     (count),
      .o_overflow  (ovf),
      .o_drop_cnt  (drop_cnt)
   );

   typedef struct {
      logic [W-1:0] data;
      int           cyc;
   } ent_t;

   ent_t         q[$];
   logic [W-1:0] beats[$];
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   int           peak = 0;
   logic         m_prev;
   logic         m_ovf;
   logic [7:0]   m_drops;
   logic [31:0]  m_ts;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: an entry logged in cycle c heads the stream from cycle c+2 on.
   always @(negedge clk) begin : compare
      logic         tv;
      logic         pop;
      logic [W-1:0] d;
      if (!rst_n) begin
         q.delete();
         m_prev  = 1'b0;
         m_ovf   = 1'b0;
         m_drops = '0;
         m_ts    = '0;
         chk("rst_tvalid", 64'(tvalid), 64'd0);
         chk("rst_tdata", 64'(tdata), 64'd0);
         chk("rst_count", 64'(count), 64'd0);
         chk("rst_overflow", 64'(ovf), 64'd0);
         chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      end else begin
         tv = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
         chk("tvalid", 64'(tvalid), 64'(tv));
         if (tv) chk("tdata", 64'(tdata), 64'(q[0].data));
         chk("count", 64'(count), 64'(q.size()));
         chk("overflow", 64'(ovf), 64'(m_ovf));
         chk("drop_cnt", 64'(drop_cnt), 64'(m_drops));
         if (int'(count) > peak) peak = int'(count);
         pop = tv && rdy;
         if (clr) begin
            q.delete();
            m_ovf   = 1'b0;
            m_drops = '0;
            m_ts    = '0;
         end else begin
            if (pop) begin
               beats.push_back(tdata);
               void'(q.pop_front());
            end
            if (trig && !m_prev) begin
`ifdef QPL_TIMESTAMP_EN
               d = {m_ts, dir, pos};
`else
               d = {dir, pos};
`endif
               if (q.size() < DEPTH) begin
                  q.push_back('{data: d, cyc: cyc});
               end else begin
                  m_ovf = 1'b1;
                  if (m_drops != 8'hFF) m_drops = m_drops + 8'd1;
               end
            end
            m_ts = m_ts + 32'd1;
         end
         m_prev = trig;
      end
      cyc++;
   end

   task automatic drive(input logic t, input logic [5:0] p, input logic d, input logic r, input logic c);
      @(posedge clk);
      #2;
      trig = t;
      pos  = p;
      dir  = d;
      rdy  = r;
      clr  = c;
   endtask

   task automatic probe();
      @(negedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      clr   = 1'b0;
      trig  = 1'b0;
      pos   = '0;
      dir   = 1'b0;
      rdy   = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_tvalid_lit", 64'(tvalid), 64'd0);
      chk("reset_count_lit", 64'(count), 64'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // three pulses, consumer always ready; first beat two cycles after the edge
      beats.delete();
      drive(1, 6'd5, 1, 1, 0);
      drive(0, 6'd5, 1, 1, 0);
      probe();
      chk("lat_n1_tvalid", 64'(tvalid), 64'd0);
      drive(1, 6'd6, 1, 1, 0);
      probe();
      chk("lat_n2_tvalid", 64'(tvalid), 64'd1);
      chk("lat_n2_tdata", 64'(tdata[6:0]), 64'h45);
      drive(0, 6'd6, 1, 1, 0);
      drive(1, 6'd7, 1, 1, 0);
      repeat (6) drive(0, 6'd0, 1, 1, 0);
      chk("t1_beats", 64'(beats.size()), 64'd3);
      if (beats.size() == 3) begin
         chk("t1_beat0", 64'(beats[0][6:0]), 64'h45);
         chk("t1_beat1", 64'(beats[1][6:0]), 64'h46);
         chk("t1_beat2", 64'(beats[2][6:0]), 64'h47);
      end

      // level held high logs once
      beats.delete();
      peak = 0;
      repeat (10) drive(1, 6'd9, 0, 0, 0);
      repeat (3) drive(0, 6'd9, 0, 0, 0);
      probe();
      chk("t2_count", 64'(count), 64'd1);
      chk("t2_peak", 64'(peak), 64'd1);
      repeat (4) drive(0, 6'd0, 0, 1, 0);
      chk("t2_beats", 64'(beats.size()), 64'd1);
      if (beats.size() == 1) chk("t2_beat0", 64'(beats[0][6:0]), 64'h09);

      // overflow: DEPTH+3 events with the consumer stalled
      for (int i = 0; i < DEPTH + 3; i++) begin
         drive(1, 6'(i), 1, 0, 0);
         drive(0, 6'(i), 1, 0, 0);
      end
      repeat (2) drive(0, 6'd0, 1, 0, 0);
      probe();
      chk("t3_count", 64'(count), 64'd16);
      chk("t3_overflow", 64'(ovf), 64'd1);
      chk("t3_drop_cnt", 64'(drop_cnt), 64'd3);

      // event coincident with pop while full
      beats.delete();
      drive(1, 6'd42, 1, 1, 0);
      drive(0, 6'd0, 1, 0, 0);
      probe();
      chk("t4_drop_cnt", 64'(drop_cnt), 64'd3);
      chk("t4_count", 64'(count), 64'd16);
      repeat (20) drive(0, 6'd0, 1, 1, 0);
      chk("t4_beats", 64'(beats.size()), 64'd17);
      if (beats.size() == 17) begin
         chk("t4_beat0", 64'(beats[0][6:0]), 64'h40);
         chk("t4_beat1", 64'(beats[1][6:0]), 64'h41);
         chk("t4_beat15", 64'(beats[15][6:0]), 64'h4F);
         chk("t4_last", 64'(beats[16][6:0]), 64'h6A);
      end

      // clear with 5 entries stored and an event in the same cycle
      for (int i = 0; i < 5; i++) begin
         drive(1, 6'(20 + i), 0, 0, 0);
         drive(0, 6'd0, 0, 0, 0);
      end
      drive(1, 6'd33, 1, 1, 1);
      drive(0, 6'd0, 0, 0, 0);
      probe();
      chk("t5_count", 64'(count), 64'd0);
      chk("t5_tvalid", 64'(tvalid), 64'd0);
      chk("t5_overflow", 64'(ovf), 64'd0);
      chk("t5_drop_cnt", 64'(drop_cnt), 64'd0);
      drive(0, 6'd0, 0, 0, 0);
      probe();
      chk("t5_tvalid_after", 64'(tvalid), 64'd0);

      // drop counter saturation
      for (int i = 0; i < DEPTH + 260; i++) begin
         drive(1, 6'(i), 0, 0, 0);
         drive(0, 6'(i), 0, 0, 0);
      end
      probe();
      chk("sat_drop_cnt", 64'(drop_cnt), 64'hFF);
      chk("sat_overflow", 64'(ovf), 64'd1);
      chk("sat_count", 64'(count), 64'd16);
      drive(0, 6'd0, 0, 0, 1);
      drive(0, 6'd0, 0, 0, 0);

`ifdef QPL_TIMESTAMP_EN
      begin
         logic [W-1:0] b0;
         logic [W-1:0] b1;
         logic [31:0]  ts0;
         logic [31:0]  ts1;
         beats.delete();
         drive(1, 6'd1, 1, 1, 0);
         repeat (3) drive(0, 6'd1, 1, 1, 0);
         drive(1, 6'd2, 1, 1, 0);
         repeat (6) drive(0, 6'd0, 1, 1, 0);
         chk("ts_beats", 64'(beats.size()), 64'd2);
         if (beats.size() == 2) begin
            b0  = beats[0];
            b1  = beats[1];
            ts0 = b0[W-1:7];
            ts1 = b1[W-1:7];
            chk("ts_delta", 64'(ts1 - ts0), 64'd4);
         end
      end
`endif

      // randomized traffic with sporadic clears and one asynchronous reset
      for (int i = 0; i < 3000; i++) begin
         if (i == 1000) begin
            @(posedge clk);
            #3;
            rst_n = 1'b0;
            trig  = 1'b0;
            clr   = 1'b0;
            repeat (2) @(negedge clk);
            @(posedge clk);
            #2;
            rst_n = 1'b1;
         end
         drive(1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 1)),
               (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
               ($urandom_range(0, 199) == 0));
      end
      repeat (4) drive(0, 6'd0, 0, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
